uart_pkt_responder: RTL and testbench
=====================================

UART_PKT_RESPONDER -- requirements
Module: uart_pkt_responder

Interface
REQ-001 SHALL have parameter ECHO_OP, default 8'hEC, the opcode byte that selects echo.
REQ-002 SHALL have parameter HDR_BYTES, default 4, the header length in bytes (opcode, reserved, len LSB, len MSB).
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports s_axis_tdata (input, 8 bits), s_axis_tvalid (input, 1 bit) and s_axis_tready (output, 1 bit): the byte stream from the UART receiver.
REQ-006 SHALL have ports m_axis_tdata (output, 8 bits), m_axis_tvalid (output, 1 bit), m_axis_tready (input, 1 bit) and m_axis_tlast (output, 1 bit): the byte stream to the UART transmitter.
REQ-007 SHALL have port busy_o, output, 1 bit: high whenever the state is not OP.
REQ-008 SHALL have port err_o, output, 1 bit: one-cycle pulse when an unknown opcode is accepted.

Function
REQ-009 SHALL transfer a byte on an input or output port only in a cycle where both valid and ready are high at the rising edge of clk_i.
REQ-010 SHALL implement the states OP, RSV, LSB, MSB, ECHO and DROP.
REQ-011 Header transitions SHALL be: OP to RSV, RSV to LSB, LSB to MSB, each on one accepted byte; the opcode is latched in OP and the length LSB is latched in LSB.
REQ-012 In MSB, the block SHALL compute remaining = {msb, lsb} - HDR_BYTES as a 16-bit value, saturating at 0.
REQ-013 From MSB, the next state SHALL be OP if remaining is 0, otherwise ECHO if the opcode equals ECHO_OP, otherwise DROP.
REQ-014 The reserved byte SHALL be ignored, whatever its value.
REQ-015 In OP, RSV, LSB and MSB, s_axis_tready SHALL be 1 whenever the output register is empty.
REQ-016 In DROP, s_axis_tready SHALL be 1; each accepted byte decrements remaining and produces no output.
REQ-017 In ECHO, s_axis_tready SHALL equal (!m_axis_tvalid | m_axis_tready); each accepted byte is loaded into a one-entry output register, giving 1 cycle of latency from input to output.
REQ-018 m_axis_tlast SHALL be 1 with the final payload byte of a packet (the byte accepted when remaining is 1), and 0 otherwise.
REQ-019 On acceptance of the final payload byte, the state SHALL return to OP in the next cycle; the first header byte of the next packet may be accepted in that cycle.
REQ-020 The output register SHALL clear m_axis_tvalid on a handshake, unless a new byte is loaded in the same cycle.
REQ-021 A full output register with m_axis_tready low SHALL hold m_axis_tdata, m_axis_tvalid and m_axis_tlast stable and SHALL hold s_axis_tready low.
REQ-022 err_o SHALL pulse for exactly 1 cycle, in the cycle after the MSB byte is accepted, when the opcode is not ECHO_OP, including when remaining is 0.
REQ-023 Data on s_axis_tdata SHALL NOT be sampled while s_axis_tvalid is low, and the state machine SHALL NOT advance.

Reset
REQ-024 Assertion of rst_ni low SHALL immediately force: state OP, remaining 0, m_axis_tvalid 0, m_axis_tdata 0, m_axis_tlast 0, err_o 0, busy_o 0.
REQ-025 Reset asserted mid-packet SHALL discard the partial packet and any buffered output byte; after release, the next accepted byte is treated as an opcode.
REQ-026 s_axis_tready SHALL be 0 while rst_ni is low.

Structure
REQ-027 The state enum, the ECHO_OP default and HDR_BYTES SHALL be defined in a shared package, uart_pkt_pkg, for reuse by the future ALU opcode handlers.
REQ-028 The output register SHALL be a sub-module, axis_reg1: a one-entry AXI-stream register carrying data and last.

Verification
REQ-029 The bench SHALL cover echo: input EC 00 08 00 DE AD BE EF -> output DE AD BE EF, tlast only on EF, busy_o low after EF.
REQ-030 The bench SHALL cover backpressure: the same packet with m_axis_tready held low for 10 cycles after DE is output -> s_axis_tready low during the stall, no loss or reorder, output DE AD BE EF.
REQ-031 The bench SHALL cover an unknown opcode: input 11 00 06 00 AA BB, then the echo packet of REQ-029 -> err_o pulses once, no output for AA BB, then DE AD BE EF.
REQ-032 The bench SHALL cover short lengths: input EC 00 04 00, then EC 00 02 00 -> no output, no err_o, state OP after each MSB byte.
REQ-033 The bench SHALL cover reset mid-payload: rst_ni pulsed low after AD of REQ-029 is accepted -> outputs at reset values; a following EC 00 05 00 77 -> output 77 with tlast.
REQ-034 The bench SHALL cover a long payload: input EC 00 04 01 plus 256 bytes 00..FF -> 256 bytes output in order, tlast only on FF.

Source files
------------

// File: rtl/uart_pkt_pkg.sv
// rtl/uart_pkt_pkg.sv - shared types and defaults for the UART packet responder
package uart_pkt_pkg;

  // Packet parser states: four header bytes, then payload handling
  typedef enum logic [2:0] {
    ST_OP,
    ST_RSV,
    ST_LSB,
    ST_MSB,
    ST_ECHO,
    ST_DROP
  } state_e;

  localparam logic [7:0] ECHO_OP_DEF   = 8'hEC;
  localparam int         HDR_BYTES_DEF = 4;

  // Payload length after removing the header; a length shorter than the header means no payload
  function automatic logic [15:0] sat_sub(input logic [15:0] a, input logic [15:0] b);
    return (a > b) ? (a - b) : 16'd0;
  endfunction

endpackage

// File: rtl/uart_pkt_responder_if.sv
// rtl/uart_pkt_responder_if.sv - byte stream bundle with data, valid, ready and last
interface uart_pkt_responder_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_reg1.sv
// rtl/axis_reg1.sv - one-entry stream register carrying data and last
module axis_reg1 (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  uart_pkt_responder_if.slave  s,
  uart_pkt_responder_if.master m
);

  logic [7:0] r_data;
  logic       r_valid;
  logic       r_last;
  logic       w_ready;

  // Accept a new byte when empty or when the held byte leaves this cycle
  assign w_ready  = !r_valid || m.tready;
  assign s.tready = w_ready;
  assign m.tdata  = r_data;
  assign m.tvalid = r_valid;
  assign m.tlast  = r_last;

  // Load on input handshake, otherwise empty on output handshake; hold while stalled
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_data  <= 8'd0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (s.tvalid && w_ready) begin
      r_data  <= s.tdata;
      r_valid <= 1'b1;
      r_last  <= s.tlast;
    end else if (m.tready) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_pkt_responder.sv
// rtl/uart_pkt_responder.sv - parses header, echoes or drops payload bytes
module uart_pkt_responder
  import uart_pkt_pkg::*;
#(
  parameter logic [7:0] ECHO_OP   = ECHO_OP_DEF,
  parameter int         HDR_BYTES = HDR_BYTES_DEF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       busy_o,
  output logic       err_o
);

  state_e      r_state;
  logic [7:0]  r_op;
  logic [7:0]  r_lsb;
  logic [15:0] r_rem;
  logic        r_err;

  logic        w_acc;
  logic [15:0] w_rem_calc;

  uart_pkt_responder_if u_ld_if ();
  uart_pkt_responder_if u_out_if ();

  // Only payload bytes in ECHO feed the output register; the final one carries last
  assign u_ld_if.tdata  = s_axis_tdata;
  assign u_ld_if.tvalid = (r_state == ST_ECHO) && s_axis_tvalid;
  assign u_ld_if.tlast  = (r_rem == 16'd1);

  assign m_axis_tdata    = u_out_if.tdata;
  assign m_axis_tvalid   = u_out_if.tvalid;
  assign m_axis_tlast    = u_out_if.tlast;
  assign u_out_if.tready = m_axis_tready;

  // DROP never touches the output register; every other state waits for room in it
  assign s_axis_tready = rst_ni && ((r_state == ST_DROP) || u_ld_if.tready);
  assign w_acc         = s_axis_tvalid && s_axis_tready;
  assign w_rem_calc    = sat_sub({s_axis_tdata, r_lsb}, 16'(HDR_BYTES));
  assign busy_o        = (r_state != ST_OP);
  assign err_o         = r_err;

  axis_reg1 u_out_reg (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .s      (u_ld_if),
    .m      (u_out_if)
  );

  // Header parsing and payload counting, one accepted byte per step
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_OP;
      r_op    <= 8'd0;
      r_lsb   <= 8'd0;
      r_rem   <= 16'd0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_OP: if (w_acc) begin
          r_op    <= s_axis_tdata;
          r_state <= ST_RSV;
        end
        ST_RSV: if (w_acc) begin
          r_state <= ST_LSB;
        end
        ST_LSB: if (w_acc) begin
          r_lsb   <= s_axis_tdata;
          r_state <= ST_MSB;
        end
        ST_MSB: if (w_acc) begin
          r_rem <= w_rem_calc;
          r_err <= (r_op != ECHO_OP);
          if (w_rem_calc == 16'd0) begin
            r_state <= ST_OP;
          end else if (r_op == ECHO_OP) begin
            r_state <= ST_ECHO;
          end else begin
            r_state <= ST_DROP;
          end
        end
        ST_ECHO, ST_DROP: if (w_acc) begin
          r_rem <= r_rem - 16'd1;
          if (r_rem == 16'd1) begin
            r_state <= ST_OP;
          end
        end
        default: r_state <= ST_OP;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_pkt_responder.sv
// tb/tb_uart_pkt_responder.sv - directed self-checking bench for uart_pkt_responder
module tb_uart_pkt_responder;

  logic clk_i;
  logic rst_ni;
  logic busy_o;
  logic err_o;

  uart_pkt_responder_if s_if ();
  uart_pkt_responder_if m_if ();

  int n_chk;
  int n_err;
  int err_cnt;
  logic [8:0] out_q[$];

  uart_pkt_responder dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .s_axis_tdata  (s_if.tdata),
    .s_axis_tvalid (s_if.tvalid),
    .s_axis_tready (s_if.tready),
    .m_axis_tdata  (m_if.tdata),
    .m_axis_tvalid (m_if.tvalid),
    .m_axis_tready (m_if.tready),
    .m_axis_tlast  (m_if.tlast),
    .busy_o        (busy_o),
    .err_o         (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Handshakes are decided by values stable at the falling edge
  always @(negedge clk_i) begin
    if (rst_ni && m_if.tvalid && m_if.tready) out_q.push_back({m_if.tlast, m_if.tdata});
    if (err_o) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    s_if.tdata  = b;
    s_if.tvalid = 1'b1;
    n = 0;
    @(negedge clk_i);
    while (!s_if.tready && n < 200) begin
      n++;
      @(negedge clk_i);
    end
    if (!s_if.tready) chk("send_tmo", 32'(s_if.tready), 32'd1);
    @(posedge clk_i);
    #1;
    s_if.tvalid = 1'b0;
  endtask

  task automatic send_q(input logic [7:0] q[$]);
    foreach (q[i]) send_byte(q[i]);
  endtask

  task automatic settle();
    repeat (4) @(posedge clk_i);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] exp[$]);
    int n;
    chk($sformatf("%s_cnt", tag), 32'(out_q.size()), 32'(exp.size()));
    n = (out_q.size() < exp.size()) ? out_q.size() : exp.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_b%0d", tag, i), 32'(out_q[i]), {23'd0, (i == exp.size() - 1), exp[i]});
  endtask

  initial begin
    logic [7:0] echo[$];
    logic [7:0] pay[$];
    logic [7:0] q[$];
    logic [7:0] big[$];
    int bad_rdy;
    int bad_hold;
    int n;

    n_chk = 0;
    n_err = 0;
    err_cnt = 0;
    rst_ni = 1'b0;
    s_if.tdata = 8'd0;
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    echo = {8'hEC, 8'h00, 8'h08, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    pay  = {8'hDE, 8'hAD, 8'hBE, 8'hEF};

    // reset state
    repeat (3) @(negedge clk_i);
    chk("rst_tvalid", 32'(m_if.tvalid), 32'd0);
    chk("rst_tdata", 32'(m_if.tdata), 32'd0);
    chk("rst_tlast", 32'(m_if.tlast), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_s_tready", 32'(s_if.tready), 32'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    settle();

    // echo
    out_q.delete();
    err_cnt = 0;
    for (int i = 0; i < echo.size(); i++) begin
      send_byte(echo[i]);
      if (i == 2) chk("echo_busy_hdr", 32'(busy_o), 32'd1);
      if (i == 4) chk("echo_latency", {23'd0, m_if.tvalid, m_if.tdata}, {23'd0, 1'b1, 8'hDE});
      if (i == 7) chk("echo_busy_end", 32'(busy_o), 32'd0);
    end
    settle();
    chk_out("echo", pay);
    chk("echo_err", 32'(err_cnt), 32'd0);
    chk("echo_tlast_idle", 32'(m_if.tlast), 32'd0);

    // backpressure
    out_q.delete();
    m_if.tready = 1'b0;
    bad_rdy = 0;
    bad_hold = 0;
    fork
      send_q(echo);
      begin
        n = 0;
        @(negedge clk_i);
        while (!m_if.tvalid && n < 100) begin
          n++;
          @(negedge clk_i);
        end
        chk("bp_first", {23'd0, m_if.tvalid, m_if.tdata}, {23'd0, 1'b1, 8'hDE});
        repeat (10) begin
          @(negedge clk_i);
          if (s_if.tready) bad_rdy++;
          if (!m_if.tvalid || m_if.tdata != 8'hDE || m_if.tlast) bad_hold++;
        end
        @(posedge clk_i);
        #1;
        m_if.tready = 1'b1;
      end
    join
    settle();
    chk("bp_s_tready_low", 32'(bad_rdy), 32'd0);
    chk("bp_hold", 32'(bad_hold), 32'd0);
    chk_out("bp", pay);

    // unknown opcode then echo
    out_q.delete();
    err_cnt = 0;
    send_q({8'h11, 8'h00, 8'h06, 8'h00});
    chk("unk_err_pulse", 32'(err_o), 32'd1);
    send_byte(8'hAA);
    chk("unk_err_clear", 32'(err_o), 32'd0);
    chk("unk_busy_drop", 32'(busy_o), 32'd1);
    send_byte(8'hBB);
    chk("unk_busy_end", 32'(busy_o), 32'd0);
    send_q(echo);
    settle();
    chk("unk_err_cnt", 32'(err_cnt), 32'd1);
    chk_out("unk", pay);

    // short lengths
    out_q.delete();
    err_cnt = 0;
    send_q({8'hEC, 8'h00, 8'h04, 8'h00});
    chk("short4_busy", 32'(busy_o), 32'd0);
    send_q({8'hEC, 8'h00, 8'h02, 8'h00});
    chk("short2_busy", 32'(busy_o), 32'd0);
    settle();
    chk("short_out_cnt", 32'(out_q.size()), 32'd0);
    chk("short_err_cnt", 32'(err_cnt), 32'd0);
    send_q({8'h22, 8'h00, 8'h04, 8'h00});
    chk("short_unk_busy", 32'(busy_o), 32'd0);
    settle();
    chk("short_unk_err", 32'(err_cnt), 32'd1);

    // reset mid-payload
    out_q.delete();
    send_q({8'hEC, 8'h00, 8'h08, 8'h00, 8'hDE, 8'hAD});
    rst_ni = 1'b0;
    #2;
    chk("mid_rst_tvalid", 32'(m_if.tvalid), 32'd0);
    chk("mid_rst_tdata", 32'(m_if.tdata), 32'd0);
    chk("mid_rst_tlast", 32'(m_if.tlast), 32'd0);
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    chk("mid_rst_err", 32'(err_o), 32'd0);
    chk("mid_rst_s_tready", 32'(s_if.tready), 32'd0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    settle();
    out_q.delete();
    send_q({8'hEC, 8'h00, 8'h05, 8'h00, 8'h77});
    settle();
    q = {8'h77};
    chk_out("post_rst", q);

    // long payload
    out_q.delete();
    big = {};
    for (int i = 0; i < 256; i++) big.push_back(8'(i));
    send_q({8'hEC, 8'h00, 8'h04, 8'h01});
    send_q(big);
    settle();
    chk_out("long", big);
    chk("long_busy", 32'(busy_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
